// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store unit with an internal word-addressed data memory.
// Little-endian byte/halfword/word accesses, sign or zero extension on loads,
// two-cycle loads (Stall in the request cycle), single-cycle stores, and a
// registered one-cycle MemErr pulse for illegal or misaligned requests.
module data_mem_lsu #(
  parameter int DEPTH_LOG2 = 10,
  parameter     INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] StoreData,
  output logic [31:0] MemData,
  output logic        Stall,
  output logic        MemErr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_word;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic        r_err;

  logic [DEPTH_LOG2-1:0] w_index;
  logic [1:0]            w_lane;
  logic                  w_fmt_load;
  logic                  w_fmt_store;
  logic                  w_aligned;
  logic                  w_load_ok;
  logic                  w_store_ok;
  logic                  w_illegal;
  logic                  w_capture;
  logic                  w_we;
  logic                  w_err_set;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_shift;
  logic                  w_unused;

  // Upper address bits are deliberately dropped so addresses wrap.
  assign w_index  = ALUResult[DEPTH_LOG2+1:2];
  assign w_lane   = ALUResult[1:0];
  assign w_unused = ^ALUResult[31:DEPTH_LOG2+2];

  // Decode funct3 legality per direction and check address alignment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_fmt_load  = 1'b0;
    w_fmt_store = 1'b0;
    w_aligned   = 1'b1;
    case (funct3)
      3'b000, 3'b001, 3'b010: begin
        w_fmt_load  = 1'b1;
        w_fmt_store = 1'b1;
      end
      3'b100, 3'b101: w_fmt_load = 1'b1;
      default: ;
    endcase
    case (funct3[1:0])
      2'b01:   w_aligned = ~w_lane[0];
      2'b10:   w_aligned = (w_lane == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  assign w_load_ok  = MemRead & ~MemWrite & w_fmt_load & w_aligned;
  assign w_store_ok = MemWrite & ~MemRead & w_fmt_store & w_aligned;
  assign w_illegal  = (MemRead | MemWrite) & ~(w_load_ok | w_store_ok);

  // Lane enables and replicated store data for SB/SH/SW.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = StoreData;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{StoreData[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{StoreData[15:0]}};
      end
      default: ;
    endcase
  end

  // FSM next state and controls; requests are only honoured in IDLE.
  always_comb begin
    w_next_state = r_state;
    Stall        = 1'b0;
    w_capture    = 1'b0;
    w_we         = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_err_set = w_illegal;
        if (w_load_ok) begin
          Stall        = 1'b1;
          w_capture    = 1'b1;
          w_next_state = S_LOAD;
        end else if (w_store_ok) begin
          w_we = 1'b1;
        end
      end
      S_LOAD:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Byte-lane memory write.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; contents survive rst_n and the
    // array can map onto block RAM.
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_index][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Capture the load word and format info; register the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word   <= '0;
      r_funct3 <= '0;
      r_lane   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_err_set;
      if (w_capture) begin
        r_word   <= r_mem[w_index];
        r_funct3 <= funct3;
        r_lane   <= w_lane;
      end
    end
  end

  assign MemErr  = r_err;
  assign w_shift = r_word >> {r_lane, 3'b000};

  // Right-justify and extend the captured lane(s).
  always_comb begin
    MemData = r_word;
    case (r_funct3)
      3'b000:  MemData = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  MemData = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  MemData = {24'd0, w_shift[7:0]};
      3'b101:  MemData = {16'd0, w_shift[15:0]};
      default: MemData = r_word;
    endcase
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed cases plus randomized
// traffic checked against a byte-array reference model.
module tb_data_mem_lsu;

  localparam int DL2    = 10;
  localparam int NBYTES = 4 << DL2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] ALUResult = 32'd0;
  logic [31:0] StoreData = 32'd0;
  logic [31:0] MemData;
  logic        Stall;
  logic        MemErr;

  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] exp_data = 32'd0;
  int          n_tests = 0;
  int          n_fail = 0;

  data_mem_lsu #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUResult(ALUResult), .StoreData(StoreData),
    .MemData(MemData), .Stall(Stall), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Access width in bytes; 0 means funct3 is not a load/store encoding.
  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit is_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr);
    int sz;
    if (rd == wr) return 0;
    sz = acc_size(f3);
    if (sz == 0) return 0;
    if (wr && f3 > 3'd2) return 0;
    if ((addr & (sz - 1)) != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int base);
    logic [31:0] v = 32'd0;
    int sz = acc_size(f3);
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // One request: check Stall in the request cycle, then MemErr/MemData in the
  // next cycle, then the pulse deasserting one cycle later.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data, input string tag);
    bit req   = rd | wr;
    bit legal = req && is_legal(rd, wr, f3, addr);
    int base  = int'(addr & (NBYTES - 1));
    @(negedge clk);
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; StoreData = data;
    #1;
    check({tag, ":stall"}, 32'(Stall), 32'(legal && rd));
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    if (legal && wr) begin
      for (int i = 0; i < acc_size(f3); i++) ref_mem[base + i] = data[8*i +: 8];
    end
    if (legal && rd) exp_data = model_load(f3, base);
    check({tag, ":err"},  32'(MemErr), 32'(req && !legal));
    check({tag, ":data"}, MemData, exp_data);
    check({tag, ":stall_n1"}, 32'(Stall), 32'd0);
    @(posedge clk); #1;
    check({tag, ":err_n2"},  32'(MemErr), 32'd0);
    check({tag, ":data_n2"}, MemData, exp_data);
  endtask

  initial begin
    // Reset state.
    #12;
    check("rst:data",  MemData, 32'd0);
    check("rst:stall", 32'(Stall), 32'd0);
    check("rst:err",   32'(MemErr), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Write-then-read.
    do_op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, "sw10");
    do_op(1, 0, 3'b010, 32'h10, 32'h0, "lw10");
    check("lw10:value", MemData, 32'hDEADBEEF);

    // Byte / half extension.
    do_op(0, 1, 3'b010, 32'h20, 32'h80FF7F01, "sw20");
    do_op(1, 0, 3'b000, 32'h22, 32'h0, "lb22");
    check("lb22:value", MemData, 32'hFFFFFFFF);
    do_op(1, 0, 3'b100, 32'h22, 32'h0, "lbu22");
    check("lbu22:value", MemData, 32'h000000FF);
    do_op(1, 0, 3'b001, 32'h22, 32'h0, "lh22");
    check("lh22:value", MemData, 32'hFFFF80FF);
    do_op(1, 0, 3'b101, 32'h20, 32'h0, "lhu20");
    check("lhu20:value", MemData, 32'h00007F01);

    // Partial stores.
    do_op(0, 1, 3'b010, 32'h30, 32'h0, "sw30");
    do_op(0, 1, 3'b000, 32'h31, 32'hAA, "sb31");
    do_op(0, 1, 3'b001, 32'h32, 32'h1234, "sh32");
    do_op(1, 0, 3'b010, 32'h30, 32'h0, "lw30");
    check("lw30:value", MemData, 32'h1234AA00);

    // Error handling against prior contents.
    do_op(1, 0, 3'b010, 32'h05, 32'h0, "lw05_misalign");
    do_op(1, 1, 3'b010, 32'h10, 32'h55555555, "rdwr_both");
    do_op(0, 1, 3'b100, 32'h10, 32'h66666666, "st_f3_100");
    do_op(1, 0, 3'b010, 32'h10, 32'h0, "lw10_after_err");
    check("lw10_after_err:value", MemData, 32'hDEADBEEF);

    // Wrap-around.
    do_op(0, 1, 3'b010, 32'h1000, 32'h11111111, "sw1000");
    do_op(1, 0, 3'b010, 32'h0000, 32'h0, "lw0000");
    check("lw0000:value", MemData, 32'h11111111);

    // Back-to-back: load held through LOAD is re-accepted in the next IDLE.
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h20;
    #1; check("b2b:stall_req", 32'(Stall), 32'd1);
    @(posedge clk); #1;
    check("b2b:stall_load", 32'(Stall), 32'd0);
    check("b2b:data1", MemData, 32'h80FF7F01);
    @(posedge clk); #1;
    check("b2b:stall_again", 32'(Stall), 32'd1);
    ALUResult = 32'h30;
    @(posedge clk); #1;
    MemRead = 1'b0;
    check("b2b:data2", MemData, 32'h1234AA00);
    exp_data = 32'h1234AA00;
    @(posedge clk); #1;

    // Reset mid-load.
    @(negedge clk);
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h10;
    @(posedge clk); #1;
    MemRead = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstload:data",  MemData, 32'd0);
    check("rstload:stall", 32'(Stall), 32'd0);
    exp_data = 32'd0;
    @(negedge clk); rst_n = 1'b1;
    do_op(1, 0, 3'b010, 32'h10, 32'h0, "lw10_post_rst");
    check("lw10_post_rst:value", MemData, 32'hDEADBEEF);

    // Fill words 0..63 so the model has known contents for random loads.
    for (int w = 0; w < 64; w++) do_op(0, 1, 3'b010, 32'(w * 4), $urandom, "fill");

    // Random traffic; bits 11:8 cleared keeps accesses in words 0..63 while
    // random upper bits exercise the wrap.
    for (int n = 0; n < 400; n++) begin
      int          kind = $urandom_range(0, 9);
      logic [31:0] addr = $urandom & 32'hFFFF_F0FF;
      logic [2:0]  f3   = 3'($urandom_range(0, 7));
      logic        rd   = (kind <= 4) || (kind == 8);
      logic        wr   = (kind >= 5 && kind <= 8);
      if (kind == 9) begin rd = 1'b0; wr = 1'b0; end
      do_op(rd, wr, f3, addr, $urandom, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
